// File: rtl/fpu_mem_request_sequencer.sv
// fpu_mem_request_sequencer
// Turns one latched buffer-drain (write) and/or buffer-fill (read) request
// into a row-by-row stream of burst-sized memory commands, limits the number
// of unacknowledged commands, and keeps making_request high until every
// command of the operation has been acknowledged.
module fpu_mem_request_sequencer #(
    parameter int BURST_BYTES      = 64,
    parameter int MEM_BUFFER_WIDTH = 512,
    parameter int COL_WIDTH        = 10,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [9:0]  req_width,
    input  logic [3:0]  req_height,
    input  logic [31:0] req_read_address,
    input  logic [31:0] req_write_address,
    input  logic [18:0] req_row_stride,
    output logic        making_request,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [31:0] cmd_addr,
    output logic [6:0]  cmd_bytes,
    output logic [3:0]  cmd_row,
    output logic [8:0]  cmd_col,
    input  logic        mem_ack,
    output logic        req_overrun
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] LP_MAXO  = OW'(MAX_OUTSTANDING);
    localparam logic [9:0]    LP_BURST = 10'(BURST_BYTES);
    localparam logic [9:0]    LP_MAXW  = 10'(MEM_BUFFER_WIDTH);
    localparam logic [3:0]    LP_MAXH  = 4'(COL_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [OW-1:0] r_out;
    logic          r_making;
    logic          r_overrun;
    logic          r_rd_pend;
    logic [9:0]    r_width;
    logic [3:0]    r_height;
    logic [18:0]   r_stride;
    logic [31:0]   r_rd_addr;
    logic [31:0]   r_row_base;
    logic [9:0]    r_col;
    logic [3:0]    r_row;

    logic          w_req;
    logic          w_issue;
    logic          w_empty;
    logic          w_ack;
    logic          w_valid;
    logic          w_accept;
    logic [9:0]    w_rem;
    logic [9:0]    w_bytes;
    logic [9:0]    w_col_next;
    logic          w_row_end;
    logic          w_last_row;
    logic          w_last_cmd;
    logic          w_to_read;
    logic [OW-1:0] w_out_next;

    assign w_req      = req_read | req_write;
    assign w_issue    = (r_state == S_WR_ISSUE) || (r_state == S_RD_ISSUE);
    assign w_empty    = (r_width == 10'd0) || (r_height == 4'd0);
    // acks arriving with nothing in flight belong to an abandoned operation
    assign w_ack      = mem_ack && (r_out != '0);
    // a slot freed by this cycle's ack can be reused in the same cycle
    assign w_valid    = w_issue && !w_empty &&
                        ((r_out < LP_MAXO) || ((r_out == LP_MAXO) && w_ack));
    assign w_accept   = w_valid && cmd_ready;
    assign w_rem      = r_width - r_col;
    assign w_bytes    = (w_rem > LP_BURST) ? LP_BURST : w_rem;
    assign w_col_next = r_col + LP_BURST;
    assign w_row_end  = (w_col_next >= r_width);
    assign w_last_row = (r_row == (r_height - 4'd1));
    assign w_last_cmd = w_accept && w_row_end && w_last_row;
    assign w_out_next = r_out + {{(OW-1){1'b0}}, w_accept} - {{(OW-1){1'b0}}, w_ack};

    assign cmd_valid      = w_valid;
    assign cmd_write      = (r_state == S_WR_ISSUE);
    assign cmd_addr       = r_row_base + {22'd0, r_col};
    assign cmd_bytes      = 7'(w_bytes);
    assign cmd_row        = r_row;
    assign cmd_col        = 9'(r_col);
    assign making_request = r_making;
    assign req_overrun    = r_overrun;

    // next-state logic: write phase first, then read phase, then wait for acks
    always_comb begin
        w_next    = r_state;
        w_to_read = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = req_write ? S_WR_ISSUE : S_RD_ISSUE;
                end
            end
            S_WR_ISSUE, S_RD_ISSUE: begin
                if (w_empty || w_last_cmd) begin
                    if ((r_state == S_WR_ISSUE) && r_rd_pend) begin
                        w_next    = S_RD_ISSUE;
                        w_to_read = 1'b1;
                    end else if (w_out_next == '0) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_out_next == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // control state: FSM, in-flight counter, busy and overrun flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_out     <= '0;
            r_making  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_out     <= w_out_next;
            r_making  <= (w_next != S_IDLE);
            r_overrun <= (r_state != S_IDLE) && w_req;
        end
    end

    // request latch and row/column walk; out-of-range sizes are clamped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_width    <= '0;
            r_height   <= '0;
            r_stride   <= '0;
            r_rd_addr  <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else if ((r_state == S_IDLE) && w_req) begin
            r_rd_pend  <= req_read;
            r_width    <= (req_width > LP_MAXW) ? LP_MAXW : req_width;
            r_height   <= (req_height > LP_MAXH) ? LP_MAXH : req_height;
            r_stride   <= req_row_stride;
            r_rd_addr  <= req_read_address;
            r_row_base <= req_write ? req_write_address : req_read_address;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_to_read) begin
            r_rd_pend  <= 1'b0;
            r_row_base <= r_rd_addr;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_accept) begin
            if (w_row_end) begin
                r_col      <= '0;
                r_row      <= r_row + 4'd1;
                r_row_base <= r_row_base + {13'd0, r_stride};
            end else begin
                r_col      <= w_col_next;
            end
        end
    end

endmodule

// File: tb/tb_fpu_mem_request_sequencer.sv
// Scoreboard bench for fpu_mem_request_sequencer: expected commands are queued
// when a request is driven and compared as the DUT hands them over.
module tb_fpu_mem_request_sequencer;

    logic        clk;
    logic        rst;
    logic        req_read;
    logic        req_write;
    logic [9:0]  req_width;
    logic [3:0]  req_height;
    logic [31:0] req_read_address;
    logic [31:0] req_write_address;
    logic [18:0] req_row_stride;
    logic        making_request;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [6:0]  cmd_bytes;
    logic [3:0]  cmd_row;
    logic [8:0]  cmd_col;
    logic        mem_ack;
    logic        req_overrun;

    fpu_mem_request_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_width         (req_width),
        .req_height        (req_height),
        .req_read_address  (req_read_address),
        .req_write_address (req_write_address),
        .req_row_stride    (req_row_stride),
        .making_request    (making_request),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_bytes         (cmd_bytes),
        .cmd_row           (cmd_row),
        .cmd_col           (cmd_col),
        .mem_ack           (mem_ack),
        .req_overrun       (req_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_ack_cyc = -10;
    int          acc      = 0;
    int          owed     = 0;
    int          ack_budget = 1000000;
    bit          ready_en = 1'b1;
    bit          stray    = 1'b0;
    logic        cv_s, mr_s, ovr_s;
    logic [63:0] cmd_s;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic w, input logic [31:0] a,
                                         input logic [6:0] b, input logic [3:0] r,
                                         input logic [8:0] c);
        return {11'd0, w, a, b, r, c};
    endfunction

    // reference model: row-major burst split of one phase
    function automatic int push_phase(input bit wr, input logic [31:0] base,
                                      input int width, input int height, input int stride);
        int n = 0;
        for (int r = 0; r < height; r++) begin
            for (int c = 0; c < width; c += 64) begin
                int          b;
                logic [31:0] a;
                b = (width - c > 64) ? 64 : (width - c);
                a = base + 32'(r * stride) + 32'(c);
                exp_q.push_back(pack(wr, a, 7'(b), 4'(r), 9'(c)));
                n++;
            end
        end
        return n;
    endfunction

    // sample at negedge, then drive next cycle's inputs just after posedge
    task automatic tick();
        @(negedge clk);
        cv_s  = cmd_valid;
        mr_s  = making_request;
        ovr_s = req_overrun;
        cmd_s = pack(cmd_write, cmd_addr, cmd_bytes, cmd_row, cmd_col);
        if (mem_ack) last_ack_cyc = cyc;
        if (cmd_valid && cmd_ready) begin
            acc++;
            owed++;
            if (exp_q.size() == 0) chk("extra_cmd", 64'd1, 64'd0);
            else chk("cmd", cmd_s, exp_q.pop_front());
        end
        cyc++;
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
        cmd_ready = ready_en;
        if (stray) begin
            mem_ack = 1'b1;
            stray   = 1'b0;
        end else if (owed > 0 && ack_budget > 0) begin
            mem_ack = 1'b1;
            owed--;
            ack_budget--;
        end else begin
            mem_ack = 1'b0;
        end
    endtask

    task automatic issue(input bit rd, input bit wr, input int w, input int h,
                         input logic [31:0] rda, input logic [31:0] wra, input int st);
        int nw = 0;
        int nr = 0;
        bit first;
        if (wr) nw = push_phase(1'b1, wra, w, h, st);
        if (rd) nr = push_phase(1'b0, rda, w, h, st);
        first = wr ? (nw > 0) : (nr > 0);
        req_read          = rd;
        req_write         = wr;
        req_width         = 10'(w);
        req_height        = 4'(h);
        req_read_address  = rda;
        req_write_address = wra;
        req_row_stride    = 19'(st);
        tick();
        chk("mr_before", 64'(mr_s), 64'd0);
        tick();
        chk("mr_first", 64'(mr_s), 64'd1);
        chk("cv_first", 64'(cv_s), 64'(first));
    endtask

    task automatic wait_done(input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (!mr_s) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_timeout"}, 64'(done), 64'd1);
        chk({tag, "_drop"}, 64'(cyc - 1 - last_ack_cyc), 64'd1);
        chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_owed"}, 64'(owed), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; req_read = 1'b0; req_write = 1'b0; req_width = '0; req_height = '0;
        req_read_address = '0; req_write_address = '0; req_row_stride = '0;
        cmd_ready = 1'b1; mem_ack = 1'b0;
        #2;
        chk("rst_mr",   64'(making_request), 64'd0);
        chk("rst_cv",   64'(cmd_valid),      64'd0);
        chk("rst_addr", 64'(cmd_addr),       64'd0);
        chk("rst_ovr",  64'(req_overrun),    64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // full-buffer read, immediate acks
        base = acc;
        issue(1'b1, 1'b0, 512, 8, 32'h1000_0000, 32'h0, 1542);
        wait_done("rd512");
        chk("rd512_count", 64'(acc - base), 64'd64);

        // single-row write with a short tail burst
        issue(1'b0, 1'b1, 100, 1, 32'h0, 32'h2000_0000, 0);
        wait_done("wr100");

        // simultaneous write and read: write drains first
        base = acc;
        issue(1'b1, 1'b1, 64, 2, 32'h5000_0000, 32'h6000_0000, 128);
        wait_done("both");
        chk("both_count", 64'(acc - base), 64'd4);

        // in-flight limit with acks withheld
        ack_budget = 0;
        base = acc;
        issue(1'b1, 1'b0, 320, 2, 32'h4000_0000, 32'h0, 320);
        for (int i = 0; i < 10; i++) tick();
        chk("lim_count4", 64'(acc - base), 64'd4);
        chk("lim_cv_low", 64'(cv_s), 64'd0);
        ack_budget = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("lim_count5", 64'(acc - base), 64'd5);
        chk("lim_cv_low5", 64'(cv_s), 64'd0);
        ack_budget = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("lim_count6", 64'(acc - base), 64'd6);
        ack_budget = 1000000;
        wait_done("lim");
        chk("lim_count", 64'(acc - base), 64'd10);

        // backpressure hold plus an ignored request while busy
        ready_en = 1'b0;
        issue(1'b1, 1'b0, 128, 1, 32'h7000_0100, 32'h0, 0);
        chk("hold0", cmd_s, exp_q[0]);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                req_read = 1'b1;
                req_read_address = 32'h0BAD_0000;
            end
            tick();
            chk("hold", cmd_s, exp_q[0]);
            chk("hold_cv", 64'(cv_s), 64'd1);
            chk("ovr", 64'(ovr_s), 64'(i == 2));
        end
        ready_en = 1'b1;
        wait_done("bp");

        // zero-width read: one busy cycle, no commands
        base = acc;
        issue(1'b1, 1'b0, 0, 4, 32'h8000_0000, 32'h0, 64);
        tick();
        chk("w0_mr_low", 64'(mr_s), 64'd0);
        chk("w0_cv", 64'(cv_s), 64'd0);
        chk("w0_count", 64'(acc - base), 64'd0);

        // asynchronous reset mid-burst, then a stray ack
        issue(1'b1, 1'b0, 512, 8, 32'h3000_0000, 32'h0, 64);
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cv",    64'(cmd_valid),      64'd0);
        chk("arst_mr",    64'(making_request), 64'd0);
        chk("arst_addr",  64'(cmd_addr),       64'd0);
        chk("arst_bytes", 64'(cmd_bytes),      64'd0);
        chk("arst_wr",    64'(cmd_write),      64'd0);
        mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        owed  = 0;
        stray = 1'b1;
        tick();
        tick();
        chk("arst_idle", 64'(mr_s), 64'd0);
        issue(1'b0, 1'b1, 100, 1, 32'h0, 32'h2000_0000, 0);
        wait_done("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
